// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter between CPU (0) and DMA (1) for one byte-wide data-memory port.
// Word accesses are sequenced one byte per cycle; load bytes are assembled little-endian.
module dmem_port_arbiter #(
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 we0,
  input  logic                 size0,
  input  logic [ADDRWIDTH-1:0] addr0,
  input  logic [31:0]          wdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic                 size1,
  input  logic [ADDRWIDTH-1:0] addr1,
  input  logic [31:0]          wdata1,
  output logic                 done0,
  output logic                 done1,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_din,
  output logic                 mem_we,
  input  logic [DATAWIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                 state_q;
  logic [1:0]             cnt_q;
  logic                   last_gnt_q;
  logic                   gnt_q;
  logic                   we_q;
  logic                   size_q;
  logic [ADDRWIDTH-1:0]   base_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic [ADDRWIDTH-1:0]   mem_addr_q;
  logic [DATAWIDTH-1:0]   mem_din_q;
  logic                   mem_we_q;
  logic                   done0_q;
  logic                   done1_q;

  logic                   gnt_d;
  logic                   we_d;
  logic                   size_d;
  logic [ADDRWIDTH-1:0]   addr_d;
  logic [31:0]            wdata_d;
  logic [1:0]             last_d;
  logic [1:0]             cnt_d;
  logic [1:0]             prev_d;
  logic [ADDRWIDTH-1:0]   mem_addr_d;

  always_comb begin
    // On a tie the requester that did not win last time is served.
    gnt_d      = (req0 && req1) ? ~last_gnt_q : req1;
    we_d       = gnt_d ? we1    : we0;
    size_d     = gnt_d ? size1  : size0;
    addr_d     = gnt_d ? addr1  : addr0;
    wdata_d    = gnt_d ? wdata1 : wdata0;
    last_d     = size_q ? 2'd3 : 2'd0;
    cnt_d      = cnt_q + 2'd1;
    prev_d     = cnt_q - 2'd1;
    mem_addr_d = base_q + ADDRWIDTH'(cnt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt_q      <= gnt_d;
            last_gnt_q <= gnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            base_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= '0;
            if (!we_d) rdata_q <= '0;
            // Port signals are registered, so byte 0 is presented as ISSUE begins.
            mem_addr_q <= addr_d;
            mem_we_q   <= we_d;
            mem_din_q  <= wdata_d[7:0];
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!we_q && cnt_q != 2'd0) rdata_q[{prev_d, 3'b000} +: 8] <= mem_dout;
          if (cnt_q == last_d) begin
            mem_we_q  <= 1'b0;
            mem_din_q <= '0;
            if (we_q) begin
              done0_q <= ~gnt_q;
              done1_q <= gnt_q;
              state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end else begin
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= wdata_q[{cnt_d, 3'b000} +: 8];
          end
        end
        S_WAIT: begin
          rdata_q[{last_d, 3'b000} +: 8] <= mem_dout;
          done0_q <= ~gnt_q;
          done1_q <= gnt_q;
          state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != S_IDLE);
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural BRAM plus a byte-array reference model
// that predicts memory contents, load results and per-cycle port activity.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, we0, size0, req1, we1, size1;
  logic [16:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1, busy, mem_we;
  logic [31:0] rdata;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  bram    [0:131071];
  logic [7:0]  ref_mem [0:131071];
  logic [31:0] exp_rdata;
  int          n_tests;
  int          n_fail;

  dmem_port_arbiter #(.ADDRWIDTH(17), .DATAWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  function automatic logic [31:0] model_load(input logic [16:0] addr, input logic sz);
    logic [31:0] r;
    logic [16:0] a;
    r = '0;
    for (int unsigned i = 0; i < (sz ? 4 : 1); i++) begin
      a = addr + 17'(i);
      r[8*i +: 8] = ref_mem[a];
    end
    return r;
  endfunction

  task automatic set_req(input int id, input logic r, input logic we, input logic sz,
                         input logic [16:0] addr, input logic [31:0] wd);
    if (id == 0) begin
      req0 = r; we0 = we; size0 = sz; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = r; we1 = we; size1 = sz; addr1 = addr; wdata1 = wd;
    end
  endtask

  task automatic do_reset();
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rdata = '0;
    @(posedge clk); #1;
  endtask

  // Starts at #1 after an edge with the DUT idle; ends the same way.
  task automatic do_txn(input int id, input logic we, input logic sz,
                        input logic [16:0] addr, input logic [31:0] wd);
    int          n, lat;
    logic [31:0] exp_r;
    logic [16:0] ea;
    logic [7:0]  ed;
    logic        dg, dn;
    n     = sz ? 4 : 1;
    lat   = we ? n + 1 : n + 2;
    exp_r = we ? exp_rdata : model_load(addr, sz);
    set_req(id, 1'b1, we, sz, addr, wd);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      dg = (id == 0) ? done0 : done1;
      dn = (id == 0) ? done1 : done0;
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy cyc%0d: got %b expected 1", k, busy); end
      n_tests++;
      if (mem_we !== (we && k <= n)) begin
        n_fail++; $display("FAIL mem_we cyc%0d: got %b expected %b", k, mem_we, we && k <= n);
      end
      ea = addr + 17'((k <= n ? k : n) - 1);
      n_tests++;
      if (mem_addr !== ea) begin n_fail++; $display("FAIL mem_addr cyc%0d: got %h expected %h", k, mem_addr, ea); end
      ed = (k <= n) ? wd[8*(k-1) +: 8] : 8'h00;
      n_tests++;
      if (mem_din !== ed) begin n_fail++; $display("FAIL mem_din cyc%0d: got %h expected %h", k, mem_din, ed); end
      n_tests++;
      if (dg !== (k == lat)) begin
        n_fail++; $display("FAIL done%0d cyc%0d: got %b expected %b", id, k, dg, k == lat);
      end
      n_tests++;
      if (dn !== 1'b0) begin n_fail++; $display("FAIL other_done cyc%0d: got %b expected 0", k, dn); end
      if (k == lat) begin
        n_tests++;
        if (rdata !== exp_r) begin n_fail++; $display("FAIL rdata: got %h expected %h", rdata, exp_r); end
        set_req(id, 1'b0, we, sz, addr, wd);
      end
    end
    if (we) begin
      for (int unsigned i = 0; i < n; i++) begin
        ea = addr + 17'(i);
        ref_mem[ea] = wd[8*i +: 8];
        n_tests++;
        if (bram[ea] !== ref_mem[ea]) begin
          n_fail++; $display("FAIL store_byte %h: got %h expected %h", ea, bram[ea], ref_mem[ea]);
        end
      end
    end else begin
      exp_rdata = exp_r;
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL post_idle: got busy=%b done=%b%b expected 0 00", busy, done0, done1);
    end
  endtask

  task automatic test_reset();
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_rdata = '0;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if ({done0, done1, busy, mem_we} !== 4'b0 || rdata !== 32'h0 || mem_addr !== 17'h0 || mem_din !== 8'h0) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: got d=%b%b busy=%b we=%b rdata=%h addr=%h din=%h expected all 0",
                 c, done0, done1, busy, mem_we, rdata, mem_addr, mem_din);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_word_store_load();
    do_txn(0, 1'b1, 1'b1, 17'h00100, 32'hDEADBEEF);
    n_tests++;
    if ({bram[17'h103], bram[17'h102], bram[17'h101], bram[17'h100]} !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_store_bytes: got %h%h%h%h expected DEADBEEF",
               bram[17'h103], bram[17'h102], bram[17'h101], bram[17'h100]);
    end
    do_txn(0, 1'b0, 1'b1, 17'h00100, 32'h0);
    n_tests++;
    if (exp_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL word_load_model: got %h expected DEADBEEF", exp_rdata);
    end
  endtask

  task automatic test_wrap_byte();
    do_txn(1, 1'b0, 1'b1, 17'h1FFFE, 32'hA5A5A5A5);
    n_tests++;
    if (exp_rdata !== 32'h0100FFFE) begin n_fail++; $display("FAIL wrap_model: got %h expected 0100FFFE", exp_rdata); end
    do_txn(0, 1'b0, 1'b0, 17'h00005, 32'h12345678);
    n_tests++;
    if (exp_rdata !== 32'h00000005) begin n_fail++; $display("FAIL byte_model: got %h expected 00000005", exp_rdata); end
    // Byte store must leave rdata untouched.
    do_txn(1, 1'b1, 1'b0, 17'h00007, 32'hFFFFFF77);
  endtask

  task automatic test_contention();
    logic [31:0] e0, e1;
    logic        x0, x1, xb;
    do_reset();
    e0 = model_load(17'h00400, 1'b1);
    e1 = model_load(17'h00800, 1'b1);
    set_req(0, 1'b1, 1'b0, 1'b1, 17'h00400, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b1, 17'h00800, 32'h0);
    for (int c = 1; c <= 28; c++) begin
      @(posedge clk); #1;
      x0 = (c == 6 || c == 20);
      x1 = (c == 13 || c == 27);
      xb = !(c == 7 || c == 14 || c == 21 || c == 28);
      n_tests++;
      if (done0 !== x0 || done1 !== x1) begin
        n_fail++; $display("FAIL contention_done c%0d: got %b%b expected %b%b", c, done0, done1, x0, x1);
      end
      n_tests++;
      if (busy !== xb) begin n_fail++; $display("FAIL contention_busy c%0d: got %b expected %b", c, busy, xb); end
      if (x0 || x1) begin
        n_tests++;
        if (rdata !== (x0 ? e0 : e1)) begin
          n_fail++; $display("FAIL contention_rdata c%0d: got %h expected %h", c, rdata, x0 ? e0 : e1);
        end
      end
      if (c == 27) begin
        set_req(0, 1'b0, 1'b0, 1'b1, 17'h00400, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b1, 17'h00800, 32'h0);
      end
    end
    exp_rdata = e1;
  endtask

  task automatic test_random();
    logic [16:0] a;
    for (int t = 0; t < 40; t++) begin
      a = 17'($urandom_range(0, 131071));
      if ($urandom_range(0, 3) == 0) a = 17'h1FFFD + 17'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) a = 17'h00300 + 17'($urandom_range(0, 7));
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom());
    end
  endtask

  task automatic test_reset_mid_store();
    logic [7:0] old2, old3;
    old2 = ref_mem[17'h202];
    old3 = ref_mem[17'h203];
    set_req(0, 1'b1, 1'b1, 1'b1, 17'h00200, 32'h11223344);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (done0 !== 1'b0 || done1 !== 1'b0) begin
        n_fail++; $display("FAIL midrst_done k%0d: got %b%b expected 00", k, done0, done1);
      end
    end
    rst_n = 1'b0;
    #1;
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    n_tests++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || done0 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: got busy=%b we=%b done0=%b expected 0 0 0", busy, mem_we, done0);
    end
    @(posedge clk); #1;
    ref_mem[17'h200] = 8'h44;
    ref_mem[17'h201] = 8'h33;
    n_tests++;
    if ({bram[17'h200], bram[17'h201], bram[17'h202], bram[17'h203]} !== {8'h44, 8'h33, old2, old3}) begin
      n_fail++;
      $display("FAIL midrst_bytes: got %h %h %h %h expected 44 33 %h %h",
               bram[17'h200], bram[17'h201], bram[17'h202], bram[17'h203], old2, old3);
    end
    rst_n = 1'b1;
    exp_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || rdata !== 32'h0) begin
        n_fail++; $display("FAIL midrst_idle c%0d: got busy=%b done=%b%b rdata=%h expected 0", c, busy, done0, done1, rdata);
      end
    end
    do_txn(1, 1'b0, 1'b1, 17'h00200, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int unsigned i = 0; i < 131072; i++) begin
      bram[i]    = 8'(i);
      ref_mem[i] = 8'(i);
    end
    test_reset();
    test_word_store_load();
    test_wrap_byte();
    test_contention();
    test_random();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
